psa_rr_arbiter: RTL and testbench
=================================

Name: psa_rr_arbiter

Overview:
- Shares one PSA_16bit unit (4 signed nibble lanes, saturating, Error = any lane saturated) between two requesters.
- Operands are registered before they drive the shared PSA, so the adder's input and output are pipeline-isolated.
- Returns a tagged, registered response under a valid/ready handshake.
- Keeps a saturating count of Error responses for debug/status.
- Sits between the decode/execute requesters (ALU PADDSB path, auxiliary requester) and the single PSA instance.

Parameters:
- CNT_W, 8, width of the error-response counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a  in  16  requester 0 operand A.
- req0_b  in  16  requester 0 operand B.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req1_valid  in  1  requester 1 has an operand pair.
- req1_a  in  16  requester 1 operand A.
- req1_b  in  16  requester 1 operand B.
- req1_ready  out  1  requester 1 operands accepted this cycle.
- psa_a  out  16  registered operand A to the shared PSA.
- psa_b  out  16  registered operand B to the shared PSA.
- psa_sum  in  16  PSA result (combinational from psa_a/psa_b).
- psa_error  in  1  PSA overflow flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester the response belongs to.
- rsp_sum  out  16  captured PSA sum.
- rsp_error  out  1  captured PSA Error.
- err_cnt  out  CNT_W  number of responses with rsp_error=1, saturating.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - state=IDLE.
  - req0_ready=req1_ready=0.
  - psa_a=psa_b=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_error=0.
  - err_cnt=0.
  - last_grant=1, so requester 0 wins the first contention.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - grant = the only valid requester; if both are valid, the requester != last_grant.
  - reqN_ready=1 combinationally, only for the granted N, and only in IDLE.
  - On acceptance (valid&&ready) at edge T: psa_a/psa_b <= reqN_a/b, gid <= N, last_grant <= N, state <= EXEC.
  - With no valid requester: stay in IDLE; all ready=0.
- EXEC (cycle T+1):
  - psa_a/psa_b are stable.
  - At the edge: rsp_sum <= psa_sum, rsp_error <= psa_error, rsp_id <= gid, rsp_valid <= 1, state <= RESP.
- RESP (rsp_valid=1 from T+2):
  - rsp_id/rsp_sum/rsp_error are held stable until rsp_ready=1.
  - On handshake: rsp_valid <= 0, state <= IDLE; err_cnt increments if rsp_error=1, unless already all-ones (saturate, no wrap).
  - No request is accepted in EXEC or RESP; both ready=0.
- Latency and throughput:
  - Accept-to-rsp_valid is 2 cycles.
  - Peak throughput is 1 operation per 3 cycles when rsp_ready is held high.
- Requester rules:
  - A requester must hold valid and operands until ready.
  - Deasserting valid before ready is legal; nothing is accepted and last_grant is unchanged.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1,...
- psa_a/psa_b are not cleared after an operation; they hold the last operands until the next acceptance.
- Reset mid-operation: from any state, the next edge with rst=1 forces all reset values.
  - The in-flight result is discarded; no response is emitted.
  - err_cnt is cleared.
- rst has priority over all handshakes in the same cycle.

Test Plan:
- Reset then idle, both valid=0 for 5 cycles -> all outputs 0, err_cnt=0, ready never asserted.
- Single request: req0 a=0x1234 b=0x1111, rsp_ready=1 -> req0_ready at T, rsp_valid at T+2, rsp_id=0, rsp_sum=0x2345, rsp_error=0, err_cnt=0.
- Saturation: req1 a=0x7111 b=0x1111 -> rsp_id=1, rsp_sum=0x7222, rsp_error=1, err_cnt=1. Then a=0x8000 b=0xF000 -> rsp_sum=0x8000, rsp_error=1, err_cnt=2.
- Contention:
  - Both valid continuously after reset, 4 operations -> grant order 0,1,0,1.
  - rsp_id sequence 0,1,0,1.
  - Each ready is a single-cycle pulse, 3 cycles apart.
- Backpressure: rsp_ready=0 for 6 cycles during RESP -> rsp_* stable, no ready asserted, no new accept. rsp_ready=1 -> next accept on the following cycle.
- Reset mid-op and counter saturation:
  - rst in EXEC -> no rsp_valid, last_grant=1.
  - With CNT_W=2, 5 error responses -> err_cnt=3.

Source files
------------

// File: rtl/psa_rr_arbiter.sv
// psa_rr_arbiter: round-robin sharing of one registered-operand PSA unit between two requesters
module psa_rr_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  output logic             req1_ready,
  output logic [15:0]      psa_a,
  output logic [15:0]      psa_b,
  input  logic [15:0]      psa_sum,
  input  logic             psa_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_sum,
  output logic             rsp_error,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [15:0] psa_a_q, psa_a_d, psa_b_q, psa_b_d, rsp_sum_q, rsp_sum_d;
  logic gid_q, gid_d, last_grant_q, last_grant_d;
  logic rsp_id_q, rsp_id_d, rsp_error_q, rsp_error_d, rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic grant, accept;
  assign grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign psa_a      = psa_a_q;
  assign psa_b      = psa_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_error  = rsp_error_q;
  assign err_cnt    = err_cnt_q;
  // Capture the winner's operands, then the PSA result one cycle later, then hold until consumed
  always_comb begin
    state_d      = state_q;
    psa_a_d      = psa_a_q;
    psa_b_d      = psa_b_q;
    gid_d        = gid_q;
    last_grant_d = last_grant_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_error_d  = rsp_error_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        psa_a_d      = grant ? req1_a : req0_a;
        psa_b_d      = grant ? req1_b : req0_b;
        gid_d        = grant;
        last_grant_d = grant;
        state_d      = EXEC;
      end
      EXEC: begin
        rsp_sum_d   = psa_sum;
        rsp_error_d = psa_error;
        rsp_id_d    = gid_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        err_cnt_d   = (rsp_error_q && !(&err_cnt_q)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State register; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      psa_a_q      <= '0;
      psa_b_q      <= '0;
      gid_q        <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_sum_q    <= '0;
      rsp_error_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      psa_a_q      <= psa_a_d;
      psa_b_q      <= psa_b_d;
      gid_q        <= gid_d;
      last_grant_q <= last_grant_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_error_q  <= rsp_error_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      err_cnt_q    <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_psa_rr_arbiter.sv
// tb_psa_rr_arbiter: directed and randomized checks of the shared-PSA round-robin arbiter
module tb_psa_rr_arbiter;
  logic clk = 1'b0, rst;
  logic req0_valid, req1_valid, rsp_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_error, psa_error;
  logic [15:0] psa_a, psa_b, psa_sum, rsp_sum;
  logic [7:0] err_cnt;
  logic s_r0, s_r1, s_rv, s_id, s_err, s_perr;
  logic [15:0] s_pa, s_pb, s_psum, s_rsum;
  logic [1:0] s_cnt;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  function automatic logic [16:0] psa(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic e;
    int x;
    s = '0;
    e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = $signed(a[4*i+:4]) + $signed(b[4*i+:4]);
      if (x > 7) begin x = 7; e = 1'b1; end
      if (x < -8) begin x = -8; e = 1'b1; end
      s[4*i+:4] = x[3:0];
    end
    return {e, s};
  endfunction
  assign {psa_error, psa_sum} = psa(psa_a, psa_b);
  assign {s_perr, s_psum}     = psa(s_pa, s_pb);
  psa_rr_arbiter u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .psa_a(psa_a), .psa_b(psa_b), .psa_sum(psa_sum), .psa_error(psa_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_error(rsp_error), .err_cnt(err_cnt)
  );
  psa_rr_arbiter #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s_r1),
    .psa_a(s_pa), .psa_b(s_pb), .psa_sum(s_psum), .psa_error(s_perr),
    .rsp_valid(s_rv), .rsp_ready(rsp_ready), .rsp_id(s_id), .rsp_sum(s_rsum),
    .rsp_error(s_err), .err_cnt(s_cnt)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_idle;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0;
    req0_b = '0;
    req1_a = '0;
    req1_b = '0;
    rsp_ready = 1'b1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    drive_idle;
    do_reset;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_error, rsp_sum, psa_a, psa_b, err_cnt, s_cnt} !== '0)
        begin n_bad++; $display("FAIL reset_idle c=%0d: got rdy=%b%b rv=%b id=%b err=%b sum=%h pa=%h pb=%h cnt=%0d expected all zero",
          c, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_error, rsp_sum, psa_a, psa_b, err_cnt); end
      tick;
    end
  endtask
  task automatic test_directed_ops;
    logic        tid [3];
    logic [15:0] ta [3], tb_ [3], ts [3];
    logic        te [3];
    int ec;
    tid = '{1'b0, 1'b1, 1'b1};
    ta  = '{16'h1234, 16'h7111, 16'h8000};
    tb_ = '{16'h1111, 16'h1111, 16'hF000};
    ts  = '{16'h2345, 16'h7222, 16'h8000};
    te  = '{1'b0, 1'b1, 1'b1};
    ec = 0;
    drive_idle;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      if (tid[i]) begin req1_valid = 1'b1; req1_a = ta[i]; req1_b = tb_[i]; end
      else begin req0_valid = 1'b1; req0_a = ta[i]; req0_b = tb_[i]; end
      @(negedge clk);
      n_cmp++;
      if ({req0_ready, req1_ready} !== {!tid[i], tid[i]})
        begin n_bad++; $display("FAIL op%0d_ready: got %b%b expected %b%b", i, req0_ready, req1_ready, !tid[i], tid[i]); end
      tick;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, req0_ready, req1_ready, psa_a, psa_b} !== {3'b000, ta[i], tb_[i]})
        begin n_bad++; $display("FAIL op%0d_exec: got rv=%b pa=%h pb=%h expected rv=0 pa=%h pb=%h", i, rsp_valid, psa_a, psa_b, ta[i], tb_[i]); end
      tick;
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_error, err_cnt} !== {1'b1, tid[i], ts[i], te[i], 8'(ec)})
        begin n_bad++; $display("FAIL op%0d_rsp: got rv=%b id=%b sum=%h err=%b cnt=%0d expected rv=1 id=%b sum=%h err=%b cnt=%0d",
          i, rsp_valid, rsp_id, rsp_sum, rsp_error, err_cnt, tid[i], ts[i], te[i], ec); end
      tick;
      if (te[i]) ec++;
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, err_cnt, psa_a} !== {1'b0, 8'(ec), ta[i]})
        begin n_bad++; $display("FAIL op%0d_done: got rv=%b cnt=%0d pa=%h expected rv=0 cnt=%0d pa=%h", i, rsp_valid, err_cnt, psa_a, ec, ta[i]); end
      tick;
    end
  endtask
  task automatic test_contention;
    logic [16:0] r;
    int op;
    drive_idle;
    do_reset;
    req0_valid = 1'b1; req0_a = 16'($urandom); req0_b = 16'($urandom);
    req1_valid = 1'b1; req1_a = 16'($urandom); req1_b = 16'($urandom);
    r = '0;
    for (int c = 0; c < 12; c++) begin
      op = c / 3;
      @(negedge clk);
      n_cmp++;
      if ({req0_ready, req1_ready} !== ((c % 3 == 0) ? (op[0] ? 2'b01 : 2'b10) : 2'b00))
        begin n_bad++; $display("FAIL contention_ready c=%0d: got %b%b expected grant to %0d only at c%%3==0", c, req0_ready, req1_ready, op[0]); end
      if (c % 3 == 0) r = op[0] ? psa(req1_a, req1_b) : psa(req0_a, req0_b);
      if (c % 3 == 2) begin
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_error} !== {1'b1, op[0], r[15:0], r[16]})
          begin n_bad++; $display("FAIL contention_rsp op=%0d: got rv=%b id=%b sum=%h err=%b expected rv=1 id=%b sum=%h err=%b",
            op, rsp_valid, rsp_id, rsp_sum, rsp_error, op[0], r[15:0], r[16]); end
      end
      tick;
      if (c % 3 == 0) begin
        if (op[0]) begin req1_a = 16'($urandom); req1_b = 16'($urandom); end
        else begin req0_a = 16'($urandom); req0_b = 16'($urandom); end
      end
    end
    drive_idle;
  endtask
  task automatic test_backpressure;
    drive_idle;
    do_reset;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0123; req0_b = 16'h0321;
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h1111; req1_b = 16'h2222;
    tick;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_error, req0_ready, req1_ready, psa_a} !== {2'b10, 16'h0444, 3'b000, 16'h0123})
        begin n_bad++; $display("FAIL backpressure_hold c=%0d: got rv=%b id=%b sum=%h err=%b rdy=%b%b pa=%h expected rv=1 id=0 sum=0444 err=0 rdy=00 pa=0123",
          c, rsp_valid, rsp_id, rsp_sum, rsp_error, req0_ready, req1_ready, psa_a); end
      tick;
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b001)
      begin n_bad++; $display("FAIL backpressure_next: got rv=%b rdy=%b%b expected rv=0 rdy=01", rsp_valid, req0_ready, req1_ready); end
    tick;
    req1_valid = 1'b0;
    tick;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_error} !== {2'b11, 16'h3333, 1'b0})
      begin n_bad++; $display("FAIL backpressure_rsp2: got rv=%b id=%b sum=%h err=%b expected rv=1 id=1 sum=3333 err=0", rsp_valid, rsp_id, rsp_sum, rsp_error); end
    tick;
  endtask
  task automatic test_reset_mid_op;
    drive_idle;
    do_reset;
    req1_valid = 1'b1; req1_a = 16'h7000; req1_b = 16'h1000;
    tick;
    req1_valid = 1'b0;
    tick;
    tick;
    @(negedge clk);
    n_cmp++;
    if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL midrst_pre_cnt: got %0d expected 1", err_cnt); end
    req0_valid = 1'b1; req0_a = 16'h7777; req0_b = 16'h7777;
    tick;
    req0_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, err_cnt, psa_a, req0_ready, req1_ready} !== '0)
        begin n_bad++; $display("FAIL midrst_quiet c=%0d: got rv=%b cnt=%0d pa=%h rdy=%b%b expected all zero", c, rsp_valid, err_cnt, psa_a, req0_ready, req1_ready); end
      tick;
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10)
      begin n_bad++; $display("FAIL midrst_first_grant: got %b%b expected 10", req0_ready, req1_ready); end
    tick;
    drive_idle;
    tick;
    tick;
  endtask
  task automatic test_cnt_saturation;
    drive_idle;
    do_reset;
    for (int k = 1; k <= 5; k++) begin
      req0_valid = 1'b1; req0_a = 16'h7000; req0_b = 16'h7000;
      tick;
      req0_valid = 1'b0;
      tick;
      tick;
      @(negedge clk);
      n_cmp++;
      if ({err_cnt, s_cnt} !== {8'(k), 2'(k > 3 ? 3 : k)})
        begin n_bad++; $display("FAIL cnt_sat k=%0d: got cnt8=%0d cnt2=%0d expected cnt8=%0d cnt2=%0d", k, err_cnt, s_cnt, k, (k > 3 ? 3 : k)); end
      tick;
    end
  endtask
  task automatic test_random;
    int busy, age, last, cnt;
    logic e0, e1, acc0, acc1, exp_id;
    logic [16:0] exp_r;
    drive_idle;
    do_reset;
    busy = 0; age = 0; last = 1; cnt = 0;
    acc0 = 1'b0; acc1 = 1'b0; exp_id = 1'b0; exp_r = '0;
    for (int c = 0; c < 600; c++) begin
      if (!req0_valid || acc0) begin req0_valid = 1'($urandom); req0_a = 16'($urandom); req0_b = 16'($urandom); end
      else if ($urandom_range(7) == 0) req0_valid = 1'b0;
      if (!req1_valid || acc1) begin req1_valid = 1'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom); end
      else if ($urandom_range(7) == 0) req1_valid = 1'b0;
      rsp_ready = ($urandom_range(3) != 0);
      e0 = (busy == 0) && req0_valid && (!req1_valid || last == 1);
      e1 = (busy == 0) && req1_valid && (!req0_valid || last == 0);
      @(negedge clk);
      n_cmp++;
      if ({req0_ready, req1_ready, s_r0, s_r1} !== {e0, e1, e0, e1})
        begin n_bad++; $display("FAIL rand_ready c=%0d: got %b%b/%b%b expected %b%b", c, req0_ready, req1_ready, s_r0, s_r1, e0, e1); end
      n_cmp++;
      if ({rsp_valid, s_rv} !== {2{busy != 0 && age >= 2}})
        begin n_bad++; $display("FAIL rand_rsp_valid c=%0d: got %b/%b expected %b", c, rsp_valid, s_rv, busy != 0 && age >= 2); end
      if (busy != 0 && age >= 2) begin
        n_cmp++;
        if ({rsp_id, rsp_error, rsp_sum, s_id, s_err, s_rsum} !== {exp_id, exp_r, exp_id, exp_r})
          begin n_bad++; $display("FAIL rand_rsp c=%0d: got id=%b err=%b sum=%h expected id=%b err=%b sum=%h", c, rsp_id, rsp_error, rsp_sum, exp_id, exp_r[16], exp_r[15:0]); end
      end
      n_cmp++;
      if ({err_cnt, s_cnt} !== {8'(cnt > 255 ? 255 : cnt), 2'(cnt > 3 ? 3 : cnt)})
        begin n_bad++; $display("FAIL rand_cnt c=%0d: got %0d/%0d expected %0d", c, err_cnt, s_cnt, cnt); end
      tick;
      acc0 = e0;
      acc1 = e1;
      if (e0 || e1) begin
        busy = 1; age = 1; exp_id = e1; last = e1 ? 1 : 0;
        exp_r = e1 ? psa(req1_a, req1_b) : psa(req0_a, req0_b);
      end else if (busy != 0 && age >= 2 && rsp_ready) begin
        busy = 0;
        if (exp_r[16]) cnt++;
      end else if (busy != 0) age++;
    end
    drive_idle;
  endtask
  initial begin
    rst = 1'b1;
    drive_idle;
    test_reset;
    test_directed_ops;
    test_contention;
    test_backpressure;
    test_reset_mid_op;
    test_cnt_saturation;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
